// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, state and alignment definitions for the memory stage
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memstate_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return (lowBits & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/llsc_link.sv
// rtl/llsc_link.sv - load-linked reservation register with store and coherence clearing
module llsc_link #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              setLink,
  input  logic [WORD_W-3:0] setWord,
  input  logic              storeDone,
  input  logic [WORD_W-3:0] storeWord,
  input  logic              clrReq,
  input  logic [WORD_W-3:0] clrWord,
  input  logic [WORD_W-3:0] checkWord,
  output logic              linkMatch
);

  logic              linkValid;
  logic [WORD_W-3:0] linkWord;

  // A new ll reservation wins over a clear arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      linkValid <= 1'b0;
      linkWord  <= '0;
    end else if (setLink) begin
      linkValid <= 1'b1;
      linkWord  <= setWord;
    end else if ((storeDone && storeWord == linkWord) || (clrReq && clrWord == linkWord)) begin
      linkValid <= 1'b0;
    end
  end

  assign linkMatch = linkValid && (checkWord == linkWord);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - held dcache request controller for the memory stage
// Optional load-linked/store-conditional support is enabled with LLSC_EN.
module mem_access_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              op_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] store_data,
  input  logic              advance,
  input  logic              flush,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
`ifdef LLSC_EN
  input  logic              ll,
  input  logic              sc,
  input  logic              link_clr,
  input  logic [WORD_W-1:0] link_addr,
`endif
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmemLoad,
  output logic              mem_stall,
  output logic              align_err
);

  localparam logic [WORD_W-1:0] SC_OK = {{(WORD_W-1){1'b0}}, 1'b1};

  memstate_t         state;
  logic              holdRen, holdWen, kill;
  logic              memInstr, memop, scFail, curSc;
  logic              idleRen, idleWen, reqActive, killNow;
  logic [WORD_W-1:0] load_q, loadNext;

  assign memInstr  = op_valid & (MemRead | MemWrite);
  assign align_err = memInstr & isMisaligned(addr[1:0]);

`ifdef LLSC_EN
  logic       holdSc, holdLl, curLl, linkMatch, setLink, storeDone;
  logic [1:0] unusedLinkBits;

  assign unusedLinkBits = link_addr[1:0];
  assign scFail    = memInstr & sc & ~align_err & ~linkMatch;
  assign curSc     = (state == BUSY) ? holdSc : sc;
  assign curLl     = (state == BUSY) ? holdLl : ll;
  // A squashed ll still finishes on the bus but must not leave a reservation.
  assign setLink   = dhit & dmemREN & curLl & ~((state == BUSY) & killNow);
  assign storeDone = dhit & dmemWEN;

  llsc_link #(.WORD_W(WORD_W)) u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .setLink   (setLink),
    .setWord   (addr[WORD_W-1:2]),
    .storeDone (storeDone),
    .storeWord (addr[WORD_W-1:2]),
    .clrReq    (link_clr),
    .clrWord   (link_addr[WORD_W-1:2]),
    .checkWord (addr[WORD_W-1:2]),
    .linkMatch (linkMatch)
  );
`else
  assign scFail = 1'b0;
  assign curSc  = 1'b0;
`endif

  assign memop   = memInstr & ~align_err & ~scFail;
  assign idleRen = nRST & memop & MemRead & ~flush;
  assign idleWen = nRST & memop & MemWrite & ~flush;

  always_comb begin
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    case (state)
      IDLE: begin
        dmemREN = idleRen;
        dmemWEN = idleWen;
      end
      BUSY: begin
        dmemREN = nRST & holdRen;
        dmemWEN = nRST & holdWen;
      end
      default: begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
    endcase
  end

  assign reqActive = dmemREN | dmemWEN;
  assign mem_stall = reqActive & ~dhit;
  assign killNow   = kill | flush;
  assign loadNext  = (curSc & dmemWEN) ? SC_OK : dload;
  assign dmemLoad  = dhit ? loadNext : ((scFail && state == IDLE) ? '0 : load_q);
  assign dmemaddr  = addr;
  assign dmemstore = store_data;

  // The request kind is latched on issue so a flush or input change cannot alter it mid-flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      load_q  <= '0;
      kill    <= 1'b0;
      holdRen <= 1'b0;
      holdWen <= 1'b0;
`ifdef LLSC_EN
      holdSc  <= 1'b0;
      holdLl  <= 1'b0;
`endif
    end else begin
      if (dhit && (dmemREN || (curSc && dmemWEN))) begin
        load_q <= loadNext;
      end
      case (state)
        IDLE: begin
          if (reqActive) begin
            holdRen <= dmemREN;
            holdWen <= dmemWEN;
            kill    <= 1'b0;
`ifdef LLSC_EN
            holdSc  <= curSc;
            holdLl  <= curLl;
`endif
            if (!dhit) begin
              state <= BUSY;
            end else if (!advance) begin
              state <= DONE;
            end
          end
        end
        BUSY: begin
          if (dhit) begin
            state <= (advance || killNow) ? IDLE : DONE;
            kill  <= 1'b0;
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        DONE: begin
          if (advance || flush) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
